// File: rtl/control_types.sv
// Shared types and constants for the instruction fetch unit.
package control_types;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPCODE_W  = 5;
    localparam int unsigned FUNCT_W   = 4;
    localparam int unsigned TMO_CNT_W = 8;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_ILLEGAL  = 2'd1,
        FAULT_MISALIGN = 2'd2,
        FAULT_TIMEOUT  = 2'd3
    } fault_code;

    typedef enum logic {
        PC_FOUR = 1'b0,
        ALU_OUT = 1'b1
    } pc_ctrl;

    function automatic logic [OPCODE_W-1:0] inst_opcode(input logic [XLEN-1:0] w);
        return w[6:2];
    endfunction

    function automatic logic [FUNCT_W-1:0] inst_funct(input logic [XLEN-1:0] w);
        return {w[30], w[14:12]};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit boundary: instruction memory port plus the decode/execute handshake.
interface inst_fetch_unit_if;
    import control_types::*;

    logic                imem_req;
    logic [XLEN-1:0]     imem_addr;
    logic                imem_rvalid;
    logic [XLEN-1:0]     imem_rdata;
    logic                inst_out_vld;
    logic                inst_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  inst;
    logic [XLEN-1:0]     inst_word;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_four;
    pc_ctrl              pc_sel;
    logic [XLEN-1:0]     alu_data;
    logic                inst_vld;
    logic                halted;
    fault_code           fault;

    modport master (
        output imem_req, imem_addr, inst_out_vld, opcode, inst, inst_word,
               pc, pc_four, halted, fault,
        input  imem_rvalid, imem_rdata, inst_ready, pc_sel, alu_data, inst_vld
    );

    modport slave (
        input  imem_req, imem_addr, inst_out_vld, opcode, inst, inst_word,
               pc, pc_four, halted, fault,
        output imem_rvalid, imem_rdata, inst_ready, pc_sel, alu_data, inst_vld
    );

endinterface

// File: rtl/ifu_timeout_cnt.sv
// Counts un-answered WAIT cycles; expired flags the cycle whose increment reaches the limit.
module ifu_timeout_cnt
    import control_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_CNT_W-1:0] r_count;
    logic [TMO_CNT_W-1:0] w_count_nxt;

    assign w_count_nxt = r_count + TMO_CNT_W'(1);
    assign expired     = (w_count_nxt == TMO_CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, fetches one instruction at a time,
// presents it to decode and halts on illegal, misaligned or timed-out fetches.
module inst_fetch_unit
    import control_types::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_unit_if.master bus
);

    fetch_state          r_state;
    fetch_state          w_state_nxt;
    fault_code           r_fault;
    fault_code           w_fault_nxt;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_pc_four;
    logic [XLEN-1:0]     w_pc_nxt;
    logic [XLEN-1:0]     w_pc_plus4;
    logic [XLEN-1:0]     w_target;
    logic [XLEN-1:0]     r_inst_q;
    logic [XLEN-1:0]     w_inst_nxt;
    logic [XLEN-1:0]     r_inst_word;
    logic [OPCODE_W-1:0] r_opcode;
    logic [FUNCT_W-1:0]  r_inst;
    logic                r_imem_req;
    logic                r_out_vld;
    logic                r_halted;
    logic                w_capture;
    logic                w_cnt_clr;
    logic                w_cnt_en;
    logic                w_tmo_expired;

    ifu_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_cnt_clr),
        .en     (w_cnt_en),
        .expired(w_tmo_expired)
    );

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_target   = bus.alu_data & ~XLEN'(1);
    assign w_inst_nxt = w_capture ? bus.imem_rdata : r_inst_q;

    // Next-state, next-PC and fault selection.
    always_comb begin
        w_state_nxt = r_state;
        w_fault_nxt = r_fault;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        unique case (r_state)
            FETCH: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_tmo_expired) begin
                        w_state_nxt = HALT;
                        w_fault_nxt = FAULT_TIMEOUT;
                    end
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    if (!bus.inst_vld) begin
                        w_state_nxt = HALT;
                        w_fault_nxt = FAULT_ILLEGAL;
                    end else if (bus.pc_sel == ALU_OUT) begin
                        if (w_target[1]) begin
                            w_state_nxt = HALT;
                            w_fault_nxt = FAULT_MISALIGN;
                        end else begin
                            w_pc_nxt    = w_target;
                            w_state_nxt = FETCH;
                        end
                    end else begin
                        w_pc_nxt    = w_pc_plus4;
                        w_state_nxt = FETCH;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State and registered outputs; req shows in the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_fault     <= FAULT_NONE;
            r_pc        <= RESET_PC;
            r_pc_four   <= RESET_PC + XLEN'(4);
            r_inst_q    <= NOP_INST;
            r_inst_word <= '0;
            r_opcode    <= '0;
            r_inst      <= '0;
            r_imem_req  <= 1'b0;
            r_out_vld   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fault    <= w_fault_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_four  <= w_pc_nxt + XLEN'(4);
            r_inst_q   <= w_inst_nxt;
            r_imem_req <= (r_state == FETCH);
            r_out_vld  <= (w_state_nxt == HOLD);
            r_halted   <= (w_state_nxt == HALT);
            if (w_state_nxt == HOLD) begin
                r_inst_word <= w_inst_nxt;
                r_opcode    <= inst_opcode(w_inst_nxt);
                r_inst      <= inst_funct(w_inst_nxt);
            end
        end
    end

    assign bus.imem_req     = r_imem_req;
    assign bus.imem_addr    = r_pc;
    assign bus.inst_out_vld = r_out_vld;
    assign bus.opcode       = r_opcode;
    assign bus.inst         = r_inst;
    assign bus.inst_word    = r_inst_word;
    assign bus.pc           = r_pc;
    assign bus.pc_four      = r_pc_four;
    assign bus.halted       = r_halted;
    assign bus.fault        = r_fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized self-checking bench for inst_fetch_unit against a cycle-exact behavioural model.
module tb_inst_fetch_unit;
    import control_types::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned TMO    = 4;

    localparam int KIND_FOUR    = 0;
    localparam int KIND_ALU     = 1;
    localparam int KIND_ILLEGAL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC      (RST_PC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_pc;
    bit          model_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        bus.inst_vld    = 1'b0;
        bus.pc_sel      = PC_FOUR;
        bus.alu_data    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        check("rst_req",     32'(bus.imem_req),     32'd0);
        check("rst_vld",     32'(bus.inst_out_vld), 32'd0);
        check("rst_halted",  32'(bus.halted),       32'd0);
        check("rst_fault",   32'(bus.fault),        32'd0);
        check("rst_addr",    bus.imem_addr,         RST_PC);
        check("rst_pc",      bus.pc,                RST_PC);
        check("rst_pc_four", bus.pc_four,           RST_PC + 32'd4);
        check("rst_word",    bus.inst_word,         32'd0);
        check("rst_opcode",  32'(bus.opcode),       32'd0);
        rst_n        = 1'b1;
        model_pc     = RST_PC;
        model_halted = 1'b0;
    endtask

    task automatic halted_idle(input int cycles, input int exp_fault);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_rvalid = 1'($urandom);
            bus.inst_ready  = 1'($urandom);
            tick();
            check("halt_req",    32'(bus.imem_req),     32'd0);
            check("halt_vld",    32'(bus.inst_out_vld), 32'd0);
            check("halt_sticky", 32'(bus.halted),       32'd1);
            check("halt_fault",  32'(bus.fault),        32'(exp_fault));
        end
        idle_inputs();
    endtask

    // One fetch/present/accept round; entered and left in the FETCH cycle.
    task automatic run_inst(input int lat, input int hold, input int kind, input logic [31:0] alu);
        logic [31:0] data;
        logic [31:0] tgt;
        check("fetch_req_lo", 32'(bus.imem_req),     32'd0);
        check("fetch_vld_lo", 32'(bus.inst_out_vld), 32'd0);
        if ($urandom_range(0, 3) == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom;
        end
        tick();
        bus.imem_rvalid = 1'b0;
        check("req",     32'(bus.imem_req),     32'd1);
        check("addr",    bus.imem_addr,         model_pc);
        check("req_vld", 32'(bus.inst_out_vld), 32'd0);
        data = $urandom;
        for (int i = 1; i <= lat; i++) begin
            bus.inst_ready = 1'($urandom);
            bus.inst_vld   = 1'b0;
            tick();
            check("wait_req",  32'(bus.imem_req),     32'd0);
            check("wait_vld",  32'(bus.inst_out_vld), 32'd0);
            check("wait_addr", bus.imem_addr,         model_pc);
            if (i == lat) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = data;
            end
        end
        tick();
        idle_inputs();
        check("vld",     32'(bus.inst_out_vld), 32'd1);
        check("word",    bus.inst_word,         data);
        check("opcode",  32'(bus.opcode),       32'(data[6:2]));
        check("inst",    32'(bus.inst),         32'({data[30], data[14:12]}));
        check("pc",      bus.pc,                model_pc);
        check("pc_four", bus.pc_four,           model_pc + 32'd4);
        check("hold_req", 32'(bus.imem_req),    32'd0);
        for (int h = 0; h < hold; h++) begin
            bus.imem_rvalid = 1'($urandom);
            bus.imem_rdata  = $urandom;
            bus.inst_vld    = 1'($urandom);
            tick();
            check("bp_vld",  32'(bus.inst_out_vld), 32'd1);
            check("bp_word", bus.inst_word,         data);
            check("bp_pc",   bus.pc,                model_pc);
            check("bp_req",  32'(bus.imem_req),     32'd0);
        end
        idle_inputs();
        bus.inst_ready = 1'b1;
        bus.inst_vld   = (kind != KIND_ILLEGAL);
        bus.pc_sel     = (kind == KIND_ALU || $urandom_range(0, 1) == 1) && kind != KIND_FOUR
                         ? ALU_OUT : PC_FOUR;
        bus.alu_data   = alu;
        tick();
        idle_inputs();
        tgt = {alu[31:1], 1'b0};
        if (kind == KIND_ILLEGAL) begin
            check("ill_halted", 32'(bus.halted), 32'd1);
            check("ill_fault",  32'(bus.fault),  32'(FAULT_ILLEGAL));
            check("ill_pc",     bus.pc,          model_pc);
            model_halted = 1'b1;
            halted_idle(3, 1);
        end else if (kind == KIND_ALU && tgt[1]) begin
            check("mis_halted", 32'(bus.halted), 32'd1);
            check("mis_fault",  32'(bus.fault),  32'(FAULT_MISALIGN));
            check("mis_pc",     bus.pc,          model_pc);
            model_halted = 1'b1;
            halted_idle(3, 2);
        end else begin
            model_pc = (kind == KIND_ALU) ? tgt : model_pc + 32'd4;
            check("next_pc",     bus.pc,           model_pc);
            check("next_halted", 32'(bus.halted),  32'd0);
            check("next_fault",  32'(bus.fault),   32'd0);
        end
    endtask

    task automatic run_timeout();
        tick();
        check("tmo_req", 32'(bus.imem_req), 32'd1);
        for (int i = 1; i < int'(TMO); i++) begin
            tick();
            check("tmo_early", 32'(bus.halted), 32'd0);
        end
        tick();
        check("tmo_halted", 32'(bus.halted), 32'd1);
        check("tmo_fault",  32'(bus.fault),  32'(FAULT_TIMEOUT));
        model_halted = 1'b1;
        halted_idle(2, 3);
    endtask

    task automatic reset_in_wait(input int cycles);
        tick();
        check("rw_req", 32'(bus.imem_req), 32'd1);
        for (int i = 0; i < cycles; i++) tick();
        do_reset();
    endtask

    initial begin
        int          r;
        int          kind;
        logic [31:0] alu;
        idle_inputs();
        do_reset();

        for (int i = 0; i < 4; i++) run_inst(1, 0, KIND_FOUR, 32'h0);
        check("seq_pc", model_pc, 32'h0000_0010);
        run_inst(1, 0, KIND_ALU, 32'h0000_0101);
        run_inst(3, 10, KIND_FOUR, 32'h0);
        run_inst(2, 0, KIND_ALU, 32'hFFFF_FFFD);
        run_inst(1, 0, KIND_FOUR, 32'h0);
        check("wrap_pc", model_pc, 32'h0000_0000);
        run_inst(1, 0, KIND_ALU, 32'h0000_0102);
        do_reset();
        run_inst(1, 0, KIND_ILLEGAL, 32'h0000_0200);
        do_reset();
        run_timeout();
        do_reset();
        reset_in_wait(1);
        run_inst(1, 0, KIND_FOUR, 32'h0);

        for (int n = 0; n < 60; n++) begin
            if (model_halted) do_reset();
            r = $urandom_range(0, 99);
            if (r < 3) begin
                run_timeout();
            end else if (r < 6) begin
                reset_in_wait($urandom_range(0, 2));
            end else begin
                r    = $urandom_range(0, 99);
                kind = (r < 5) ? KIND_ILLEGAL : (r < 50) ? KIND_ALU : KIND_FOUR;
                alu  = $urandom;
                if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
                run_inst($urandom_range(1, 3), $urandom_range(0, 3), kind, alu);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
